// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default widths for the instruction fetch unit
package fetch_pkg;

  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_INST_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous FIFO with clear, count and full/empty flags
module fetch_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; clear wins over push/pop. Pointers wrap as DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  // Entry storage needs no reset: empty slots are never presented.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch PC, single-outstanding imem requests and instruction buffer
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INST_W = FETCH_INST_W,
  parameter int DEPTH  = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              flushBack_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              imemReady_i,
  output logic              imemReq_o,
  output logic [ADDR_W-1:0] imemAddr_o,
  input  logic              imemValid_i,
  input  logic [INST_W-1:0] imemData_i,
  input  logic              isStalled_i,
  output logic              instValid_o,
  output logic [INST_W-1:0] instruction_o,
  output logic [ADDR_W-1:0] instPc_o,
  output logic              bufferFull_o
);

  localparam int EW = ADDR_W + INST_W;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              full, empty, issue, flush, push, pop;

  // Redirects are ignored before fetching has been enabled out of reset.
  assign flush = flushBack_i && (state_q != IDLE);
  // Only one request is ever outstanding, so a free slot at issue reserves room for its response.
  assign imemReq_o  = (state_q == REQ) && enable_i && (count < CW'(DEPTH));
  assign issue      = imemReq_o && imemReady_i;
  assign push       = (state_q == WAIT) && imemValid_i && !flush;
  assign pop        = instValid_o && !isStalled_i && !flushBack_i;
  assign imemAddr_o = fetch_pc_q;

  assign instValid_o   = !empty;
  assign instruction_o = instValid_o ? head[EW-1:ADDR_W] : '0;
  assign instPc_o      = instValid_o ? head[ADDR_W-1:0] : '0;
  assign bufferFull_o  = full;

  // Next-state, fetch PC and request PC; a redirect overrides the normal transition.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      IDLE:  if (enable_i) state_d = REQ;
      REQ: begin
        if (issue) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          state_d    = WAIT;
        end
      end
      WAIT:  if (imemValid_i) state_d = REQ;
      DRAIN: if (imemValid_i) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      fetch_pc_d = pc_i;
      case (state_q)
        // A request still in flight must be drained before the next one goes out.
        WAIT:    state_d = imemValid_i ? REQ : DRAIN;
        REQ:     state_d = issue ? DRAIN : REQ;
        DRAIN:   state_d = imemValid_i ? REQ : DRAIN;
        default: state_d = REQ;
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_ni  (reset_i),
    .clear_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({imemData_i, req_pc_q}),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clock_i = 1'b0;
  logic        reset_i, enable_i, flushBack_i, imemReady_i, imemValid_i, isStalled_i;
  logic [15:0] pc_i;
  logic [31:0] imemData_i;
  logic        imemReq_o, instValid_o, bufferFull_o;
  logic [15:0] imemAddr_o, instPc_o;
  logic [31:0] instruction_o;

  instruction_fetch_unit #(.ADDR_W(16), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .flushBack_i(flushBack_i),
    .pc_i(pc_i), .imemReady_i(imemReady_i), .imemReq_o(imemReq_o), .imemAddr_o(imemAddr_o),
    .imemValid_i(imemValid_i), .imemData_i(imemData_i), .isStalled_i(isStalled_i),
    .instValid_o(instValid_o), .instruction_o(instruction_o), .instPc_o(instPc_o),
    .bufferFull_o(bufferFull_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int failures = 0;

  // Transaction-level reference: delivered-instruction queue plus one memory request tracker.
  fetch_entry_t mq[$];
  bit           m_out, m_stale, m_started, resp_now;
  logic [15:0]  m_pc, m_addr;
  int           m_rem;
  int           lat_min = 1, lat_max = 1;

  typedef struct {
    bit          en;
    bit          stall;
    bit          req;
    logic [15:0] addr;
    bit          valid;
    logic [15:0] pc;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [31:0] tag(input logic [15:0] a);
    return {a ^ 16'h5A3C, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = 0; m_stale = 0; m_started = 0; m_pc = '0; m_addr = '0; m_rem = 0;
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_req"}, imemReq_o, 0);
    chk({name, "_addr"}, imemAddr_o, 0);
    chk({name, "_valid"}, instValid_o, 0);
    chk({name, "_inst"}, instruction_o, 0);
    chk({name, "_pc"}, instPc_o, 0);
    chk({name, "_full"}, bufferFull_o, 0);
  endtask

  // Drive the memory response for this cycle and compare outputs with the reference.
  task automatic step_pre();
    resp_now    = m_out && (m_rem == 0);
    imemValid_i = resp_now;
    imemData_i  = resp_now ? tag(m_addr) : 32'($urandom);
    #1;
    chk("imemReq", imemReq_o, m_started && enable_i && !m_out && (mq.size() < DEPTH));
    chk("imemAddr", imemAddr_o, m_pc);
    chk("instValid", instValid_o, mq.size() != 0);
    chk("bufferFull", bufferFull_o, mq.size() == DEPTH);
    if (mq.size() != 0) begin
      chk("instPc", instPc_o, mq[0].pc);
      chk("instruction", instruction_o, mq[0].inst);
    end
  endtask

  // Advance the reference across the clock edge.
  task automatic step_post();
    bit exp_req, issue, fl, pop;
    fetch_entry_t e;
    exp_req = m_started && enable_i && !m_out && (mq.size() < DEPTH);
    issue   = exp_req && imemReady_i;
    fl      = flushBack_i && m_started;
    pop     = (mq.size() != 0) && !isStalled_i && !flushBack_i;
    @(posedge clock_i);
    if (pop) void'(mq.pop_front());
    if (m_out) begin
      if (resp_now) begin
        if (!m_stale && !fl) begin
          e.pc = m_addr; e.inst = tag(m_addr);
          mq.push_back(e);
        end
        m_out = 0; m_stale = 0;
      end else begin
        m_rem--;
      end
    end
    if (fl) begin
      mq.delete();
      if (m_out) m_stale = 1;
    end
    if (issue) begin
      m_out = 1; m_stale = fl; m_addr = m_pc;
      m_rem = int'($urandom_range(lat_max, lat_min)) - 1;
    end
    if (fl) m_pc = pc_i;
    else if (issue) m_pc = m_pc + 16'd1;
    if (enable_i) m_started = 1;
    @(negedge clock_i);
  endtask

  task automatic step();
    step_pre();
    step_post();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    int          n;
    logic [15:0] got [2];

    reset_i = 0; enable_i = 0; flushBack_i = 0; pc_i = '0; imemReady_i = 0;
    imemValid_i = 0; imemData_i = '0; isStalled_i = 0;
    model_reset();
    repeat (2) @(negedge clock_i);
    chk_reset("reset");
    reset_i = 1;

    // Start-up: en, stall, req, addr, valid, pc with a one-cycle memory.
    vecs[0] = '{0, 0, 0, 16'd0, 0, 16'd0};
    vecs[1] = '{1, 0, 0, 16'd0, 0, 16'd0};
    vecs[2] = '{1, 0, 1, 16'd0, 0, 16'd0};
    vecs[3] = '{1, 0, 0, 16'd1, 0, 16'd0};
    vecs[4] = '{1, 0, 1, 16'd1, 1, 16'd0};
    vecs[5] = '{1, 0, 0, 16'd2, 0, 16'd0};
    vecs[6] = '{1, 0, 1, 16'd2, 1, 16'd1};
    vecs[7] = '{1, 0, 0, 16'd3, 0, 16'd0};
    vecs[8] = '{1, 0, 1, 16'd3, 1, 16'd2};
    imemReady_i = 1;
    for (int i = 0; i < 9; i++) begin
      enable_i = vecs[i].en; isStalled_i = vecs[i].stall;
      step_pre();
      chk("tbl_req", imemReq_o, vecs[i].req);
      chk("tbl_addr", imemAddr_o, vecs[i].addr);
      chk("tbl_valid", instValid_o, vecs[i].valid);
      if (vecs[i].valid) begin
        chk("tbl_pc", instPc_o, vecs[i].pc);
        chk("tbl_inst", instruction_o, tag(vecs[i].pc));
      end
      step_post();
    end

    // Hold decode stalled until the buffer fills, then release.
    isStalled_i = 1;
    repeat (14) step();
    step_pre();
    chk("stall_full", bufferFull_o, 1);
    chk("stall_noreq", imemReq_o, 0);
    chk("stall_head_pc", instPc_o, 16'd3);
    step_post();
    isStalled_i = 0;
    repeat (12) step();

    // Redirect while waiting on a slow response.
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && m_rem == 2) found = 1;
      else step();
    end
    chk("wait_issue_seen", found, 1);
    flushBack_i = 1; pc_i = 16'h0040;
    step();
    flushBack_i = 0;
    step_pre();
    chk("flush_empty", instValid_o, 0);
    chk("flush_pc", imemAddr_o, 16'h0040);
    chk("flush_drain_noreq", imemReq_o, 0);
    step_post();
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step_pre();
      if (instValid_o) begin
        chk("flush_first_pc", instPc_o, 16'h0040);
        found = 1;
      end
      step_post();
    end
    chk("flush_first_seen", found, 1);

    // Redirect coincident with a response and a would-be pop.
    lat_min = 1; lat_max = 1;
    isStalled_i = 1;
    repeat (6) step();
    isStalled_i = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && m_rem == 0 && mq.size() != 0) found = 1;
      else step();
    end
    chk("coinc_setup_seen", found, 1);
    flushBack_i = 1; pc_i = 16'h0123;
    step();
    flushBack_i = 0;
    step_pre();
    chk("coinc_empty", instValid_o, 0);
    chk("coinc_pc", imemAddr_o, 16'h0123);
    step_post();
    repeat (6) step();

    // Redirect to the top of the address space; fetch PC wraps.
    flushBack_i = 1; pc_i = 16'hFFFF;
    step();
    flushBack_i = 0;
    n = 0; got[0] = '0; got[1] = '0;
    for (int i = 0; i < 40 && n < 2; i++) begin
      step_pre();
      if (imemReq_o && imemReady_i) begin
        got[n] = imemAddr_o;
        n++;
      end
      step_post();
    end
    chk("wrap_count", n, 2);
    chk("wrap_first", got[0], 16'hFFFF);
    chk("wrap_second", got[1], 16'h0000);
    repeat (8) step();

    // Randomized traffic against the reference.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2500; i++) begin
      enable_i    = ($urandom_range(9, 0) != 0);
      isStalled_i = ($urandom_range(2, 0) == 0);
      imemReady_i = ($urandom_range(3, 0) != 0);
      flushBack_i = ($urandom_range(24, 0) == 0);
      pc_i        = ($urandom_range(3, 0) == 0) ? 16'hFFFE : 16'($urandom);
      step();
    end
    flushBack_i = 0; enable_i = 1; isStalled_i = 0; imemReady_i = 1;

    // Reset while a response is outstanding; the late response must be ignored.
    lat_min = 3; lat_max = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out) found = 1;
      else step();
    end
    chk("rst_wait_seen", found, 1);
    #2;
    reset_i = 0;
    imemValid_i = 1; imemData_i = 32'hDEADBEEF;
    @(posedge clock_i);
    @(negedge clock_i);
    chk_reset("rst_mid");
    reset_i = 1; enable_i = 0;
    #1;
    chk_reset("idle_resp");
    @(posedge clock_i);
    @(negedge clock_i);
    chk("idle_resp_ignored", instValid_o, 0);
    model_reset();
    enable_i = 1; lat_min = 1; lat_max = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step_pre();
      if (imemReq_o) begin
        chk("post_rst_addr", imemAddr_o, 16'h0000);
        found = 1;
      end
      step_post();
    end
    chk("post_rst_req_seen", found, 1);
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
